divider: RTL and testbench
==========================

Name: divider

Overview:
- Sequential 32-bit integer divide/remainder unit for the RV32M DIV, DIVU, REM and REMU instructions.
- Uses a radix-2 restoring algorithm: one trial subtraction per cycle.
- Built as the subtract-side counterpart of the combinational adder.
- Sits beside the ALU in the execute stage; the control unit stalls the single-cycle datapath on busy.

Parameters:
WIDTH, 32, operand/result width; counter is $clog2(WIDTH)+1 bits

Ports:
clk       input   1      rising-edge clock
rst_n     input   1      asynchronous active-low reset
start_in  input   1      request; sampled only in IDLE
op_in     input   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
a_in      input   WIDTH  dividend
b_in      input   WIDTH  divisor
result    output  WIDTH  quotient or remainder per captured op
busy      output  1      high from the accept edge until the done edge
done      output  1      one-cycle pulse; result valid from then on

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; result=0, busy=0, done=0; internal registers cleared.
  - Asserting reset mid-operation aborts the operation; no done is produced.
- States: IDLE, CALC, FIX.
- IDLE, start_in=1 at edge k:
  - Capture op_in, a_in, b_in; busy=1.
  - Signed ops (op_in[0]=0): store |a| and |b|. Record quotient sign = a[31]^b[31] and remainder sign = a[31].
  - If b_in==0 or signed overflow (a=0x80000000, b=0xFFFFFFFF): go to FIX directly.
  - Otherwise: remainder accumulator=0, counter=WIDTH, go to CALC.
- CALC, one iteration per edge:
  - Shift {rem, quo} left 1.
  - Trial = rem_shifted - divisor, computed in WIDTH+1 bits.
  - If trial is non-negative: rem=trial, quo[0]=1. Otherwise rem is unchanged and quo[0]=0.
  - Decrement counter. After the WIDTH-th iteration (edge k+WIDTH), go to FIX.
- FIX, single edge:
  - Select result; busy=0; done=1 for exactly one cycle; go to IDLE.
  - Normal DIV/DIVU: result = quotient, negated when signed and quotient sign=1.
  - Normal REM/REMU: result = remainder, negated when signed and remainder sign=1.
  - Divide by zero: quotient=0xFFFFFFFF (all ops); remainder=dividend a unchanged (signed and unsigned).
  - Signed overflow: quotient=0x80000000, remainder=0.
- Latency, with start accepted at edge k:
  - Normal: done high after edge k+WIDTH+1 (k+33 for WIDTH=32).
  - Special cases: done high after edge k+1.
- Handshake:
  - start_in is ignored while busy=1.
  - start_in in the same cycle done is high is accepted, because the state is already IDLE.
  - result holds its value until the next FIX edge.
  - Inputs are don't-care after capture.
- Arithmetic:
  - Absolute values and final negation are two's complement, WIDTH bits.
  - |0x80000000| = 0x80000000, which is handled correctly as unsigned.
  - No X on outputs at any time after reset.

Test Plan:
- Unsigned divide: DIVU a=100, b=7, start one cycle.
  - result=14 with a done pulse exactly 33 edges after the accept edge; busy high for 33 cycles.
  - REMU with the same operands → 2.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD (-3).
  - REM same operands → 0xFFFFFFFF (-1).
  - DIV a=7, b=0xFFFFFFFE → 0xFFFFFFFD.
- Divide by zero, done after 1 edge for each:
  - DIVU a=5, b=0 → 0xFFFFFFFF; REMU → 5.
  - DIV a=0xFFFFFFF9, b=0 → 0xFFFFFFFF; REM → 0xFFFFFFF9.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0; done after 1 edge.
  - DIVU with the same operands → 0x00000000 after 33 edges.
- Handshake:
  - Pulse start_in again at edge k+5 with different operands → ignored; first result unchanged.
  - start_in held high in the done cycle → second op accepted back-to-back.
- Reset mid-operation: assert rst_n=0 asynchronously at edge k+10 of DIVU 0xFFFFFFFF/3.
  - Outputs go to 0 immediately; no done appears.
  - After release, DIVU 0xFFFFFFFF/3 → 0x55555555.
- Reference-model sweep: random and corner operands (0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF) for all four ops.
  - Each result is compared against behavioural Verilog /, % with the RISC-V special-case rules.
  - The sweep stops with an error display on the first mismatch.

Source files
------------

// File: rtl/divider.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle; special cases resolve in a single edge.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             in_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             in_dz;
    logic             in_ovf;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             fix_signed;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // Operand conditioning at capture time
    always_comb begin
        in_signed = ~op_in[0];
        a_abs     = (in_signed && a_in[WIDTH-1]) ? (~a_in + ONE) : a_in;
        b_abs     = (in_signed && b_in[WIDTH-1]) ? (~b_in + ONE) : b_in;
        in_dz     = (b_in == '0);
        in_ovf    = in_signed && (a_in == MIN) && (b_in == '1);
    end

    // Trial subtraction: borrow lands in bit WIDTH
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};
    end

    always_comb begin
        fix_signed = ~op_q[0];
        quo_fix    = (fix_signed && qneg_q) ? (~quo_q + ONE) : quo_q;
        rem_fix    = (fix_signed && rneg_q) ? (~rem_q + ONE) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    op_d   = op_in;
                    dvd_d  = a_in;
                    dvs_d  = b_abs;
                    quo_d  = a_abs;
                    rem_d  = '0;
                    cnt_d  = CNT_INIT;
                    qneg_d = in_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    rneg_d = in_signed & a_in[WIDTH-1];
                    dz_d   = in_dz;
                    ovf_d  = in_ovf;
                    if (in_dz || in_ovf) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                unique case (1'b1)
                    dz_q:    res_d = op_q[1] ? dvd_q : '1;
                    ovf_q:   res_d = op_q[1] ? '0 : MIN;
                    default: res_d = op_q[1] ? rem_fix : quo_fix;
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign result = res_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expectations queued at issue,
// popped and compared when done pulses.
module tb_divider;

    logic        clk;
    logic        rst_n;
    logic        start_in;
    logic [1:0]  op_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];

    divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_in (start_in),
        .op_in    (op_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb_;
        sa  = a;
        sb_ = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'd0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb_) : 32'(sa / sb_);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one start pulse, queue the expectation, scramble inputs after capture
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        op_in    = op;
        a_in     = a;
        b_in     = b;
        start_in = 1'b1;
        e.res = ref_res(op, a, b);
        e.lat = ref_lat(op, a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start_in = 1'b0;
        op_in    = 2'($urandom);
        a_in     = $urandom;
        b_in     = $urandom;
    endtask

    // Bounded wait for done; lat = edges waited, bc = samples with busy high
    task automatic wait_done(output logic [31:0] res, output int lat,
                             output int bc);
        lat = 0;
        bc  = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bc++;
        end while (!done && lat < 100);
        res = result;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start_in = 1'b0;
        op_in    = 2'b00;
        a_in     = 32'd0;
        b_in     = 32'd0;
        #3;
        n_cmp++;
        if (result !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_result got %h want 00000000", result);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_done got %b want 0", done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [1:0] ops [2];
        logic [31:0] r;
        int l, bc;
        exp_t e;
        ops[0] = 2'b01;
        ops[1] = 2'b11;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'd100, 32'd7);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_bad++;
                $display("FAIL unsigned_busy_accept op=%0d got %b want 1", i, busy);
            end
            wait_done(r, l, bc);
            e = sb.pop_front();
            n_cmp++;
            if (r !== e.res) begin
                n_bad++;
                $display("FAIL unsigned_result op=%0d got %h want %h", i, r, e.res);
            end
            n_cmp++;
            if (l !== e.lat) begin
                n_bad++;
                $display("FAIL unsigned_latency op=%0d got %0d want %0d", i, l, e.lat);
            end
            n_cmp++;
            if (bc + 1 !== 33) begin
                n_bad++;
                $display("FAIL unsigned_busy_cycles op=%0d got %0d want 33", i, bc + 1);
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (done !== 1'b0 || result !== e.res) begin
                n_bad++;
                $display("FAIL unsigned_done_pulse op=%0d done=%b res=%h want done=0 res=%h",
                         i, done, result, e.res);
            end
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops [9];
        logic [31:0] as  [9];
        logic [31:0] bs  [9];
        logic [31:0] r;
        int l, bc;
        exp_t e;
        ops = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10};
        as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
        bs  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0,
                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 9; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(r, l, bc);
            e = sb.pop_front();
            n_cmp++;
            if (r !== e.res) begin
                n_bad++;
                $display("FAIL special_result #%0d got %h want %h", i, r, e.res);
            end
            n_cmp++;
            if (l !== e.lat) begin
                n_bad++;
                $display("FAIL special_latency #%0d got %0d want %0d", i, l, e.lat);
            end
        end
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(r, l, bc);
        e = sb.pop_front();
        n_cmp++;
        if (r !== 32'd0 || l !== 33) begin
            n_bad++;
            $display("FAIL divu_ovf_operands got %h lat %0d want 00000000 lat 33", r, l);
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] r;
        int l, bc, extra;
        exp_t e;
        issue(2'b01, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        start_in = 1'b1;
        op_in    = 2'b00;
        a_in     = 32'd1000;
        b_in     = 32'd3;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        wait_done(r, l, bc);
        e = sb.pop_front();
        n_cmp++;
        if (r !== e.res) begin
            n_bad++;
            $display("FAIL ignore_result got %h want %h", r, e.res);
        end
        n_cmp++;
        if (l + 5 !== e.lat) begin
            n_bad++;
            $display("FAIL ignore_latency got %0d want %0d", l + 5, e.lat);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (busy || done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_bad++;
            $display("FAIL ignore_no_restart got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        int l, bc;
        exp_t e;
        issue(2'b01, 32'd100, 32'd7);
        start_in = 1'b1;
        op_in    = 2'b00;
        a_in     = 32'd1000;
        b_in     = 32'hFFFF_FFFD;
        e.res = ref_res(2'b00, 32'd1000, 32'hFFFF_FFFD);
        e.lat = 33;
        sb.push_back(e);
        wait_done(r, l, bc);
        e = sb.pop_front();
        n_cmp++;
        if (r !== e.res || l !== e.lat) begin
            n_bad++;
            $display("FAIL b2b_first got %h lat %0d want %h lat %0d", r, l, e.res, e.lat);
        end
        @(posedge clk);
        #1;
        start_in = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept_busy got %b want 1", busy);
        end
        wait_done(r, l, bc);
        e = sb.pop_front();
        n_cmp++;
        if (r !== e.res || l !== e.lat) begin
            n_bad++;
            $display("FAIL b2b_second got %h lat %0d want %h lat %0d", r, l, e.res, e.lat);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        int l, bc, seen;
        exp_t e;
        issue(2'b01, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e = sb.pop_back();
        n_cmp++;
        if (result !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_outputs res=%h busy=%b done=%b want 0/0/0",
                     result, busy, done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_done got %0d active cycles want 0", seen);
        end
        issue(2'b01, 32'hFFFF_FFFF, 32'd3);
        wait_done(r, l, bc);
        e = sb.pop_front();
        n_cmp++;
        if (r !== 32'h5555_5555 || r !== e.res || l !== 33) begin
            n_bad++;
            $display("FAIL midreset_rerun got %h lat %0d want 55555555 lat 33", r, l);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] cor [5];
        logic [31:0] a, b, r;
        logic [1:0]  op;
        int l, bc, total;
        bit stop;
        exp_t e;
        cor = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        stop  = 1'b0;
        total = 4 * 5 * 5 + 80;
        for (int n = 0; n < total && !stop; n++) begin
            if (n < 100) begin
                op = 2'(n / 25);
                a  = cor[(n / 5) % 5];
                b  = cor[n % 5];
            end else begin
                op = 2'($urandom);
                a  = $urandom;
                b  = (n % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                if (n % 7 == 0) b = {16'h0, b[15:0]};
            end
            issue(op, a, b);
            wait_done(r, l, bc);
            e = sb.pop_front();
            n_cmp++;
            if (r !== e.res || l !== e.lat) begin
                n_bad++;
                stop = 1'b1;
                $display("FAIL sweep op=%0d a=%h b=%h got %h lat %0d want %h lat %0d",
                         op, a, b, r, l, e.res, e.lat);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_unsigned();
        test_special();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
